// File: rtl/reg_bank_mp.sv
// reg_bank_mp: parametrised register bank with one write port, per-byte write
// enables, and two independent read ports with one-cycle latency.
// Accesses to addresses at or above NUM_REGS are flagged and counted in a
// saturating 8-bit error counter.
// Build option: define REG_BANK_BYPASS_EN to make a read that hits the word
// being legally written in the same edge return the merged new value. Without
// it, the read returns the old value.
module reg_bank_mp #(
    parameter int  DATA_W   = 16,
    parameter int  NUM_REGS = 14,
    parameter int  ADDR_W   = 4,
    localparam int BE_W     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BE_W-1:0]   wr_be,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    output logic              rd_valid_a,
    output logic              rd_err_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid_b,
    output logic              rd_err_b,
    output logic              wr_err,
    input  logic              err_clr,
    output logic [7:0]        err_cnt
);

    localparam logic [ADDR_W:0] NUM_REGS_EXT = (ADDR_W + 1)'(NUM_REGS);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
    logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;
    logic              rd_valid_a_q, rd_valid_a_d;
    logic              rd_valid_b_q, rd_valid_b_d;
    logic              rd_err_a_q, rd_err_a_d;
    logic              rd_err_b_q, rd_err_b_d;
    logic              wr_err_q, wr_err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic              wr_legal, rd_legal_a, rd_legal_b;
    logic              wr_bad, rd_bad_a, rd_bad_b;
    logic [DATA_W-1:0] wr_old, wr_merged;
    logic [DATA_W-1:0] rd_val_a, rd_val_b;
    logic [1:0]        err_new;
    logic [8:0]        err_sum;

    // Replace the bytes of old_v selected by be with the matching bytes of new_v.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    // Decode address legality, look up the addressed words, and build the merged write word.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
        wr_legal   = ({1'b0, wr_addr}   < NUM_REGS_EXT);
        rd_legal_a = ({1'b0, rd_addr_a} < NUM_REGS_EXT);
        rd_legal_b = ({1'b0, rd_addr_b} < NUM_REGS_EXT);
        wr_bad     = wr_en   & ~wr_legal;
        rd_bad_a   = rd_en_a & ~rd_legal_a;
        rd_bad_b   = rd_en_b & ~rd_legal_b;
        wr_old     = '0;
        rd_val_a   = '0;
        rd_val_b   = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_addr   == ADDR_W'(i)) wr_old   = regs_q[i];
            if (rd_addr_a == ADDR_W'(i)) rd_val_a = regs_q[i];
            if (rd_addr_b == ADDR_W'(i)) rd_val_b = regs_q[i];
        end
        wr_merged = merge_bytes(wr_old, wr_data, wr_be);
`ifdef REG_BANK_BYPASS_EN
        if (wr_en && wr_legal && rd_addr_a == wr_addr) rd_val_a = wr_merged;
        if (wr_en && wr_legal && rd_addr_b == wr_addr) rd_val_b = wr_merged;
`else
        // Read-before-write: the reads above already return the pre-edge contents.
`endif
    end

    // Next register-array contents: only the legally addressed word takes the merged value.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_en && wr_legal && wr_addr == ADDR_W'(i)) regs_d[i] = wr_merged;
        end
    end

    // Next read-port state: data holds when idle, zero on an illegal address.
    always_comb begin
        rd_data_a_d  = rd_data_a_q;
        rd_valid_a_d = rd_en_a;
        rd_err_a_d   = rd_bad_a;
        if (rd_en_a) rd_data_a_d = rd_legal_a ? rd_val_a : '0;

        rd_data_b_d  = rd_data_b_q;
        rd_valid_b_d = rd_en_b;
        rd_err_b_d   = rd_bad_b;
        if (rd_en_b) rd_data_b_d = rd_legal_b ? rd_val_b : '0;

        wr_err_d = wr_bad;
    end

    // Saturating error counter: a clear still counts errors arriving in the same edge.
    always_comb begin
        err_new   = 2'({1'b0, wr_bad}) + 2'({1'b0, rd_bad_a}) + 2'({1'b0, rd_bad_b});
        err_sum   = (err_clr ? 9'd0 : {1'b0, err_cnt_q}) + 9'(err_new);
        err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    // State update on the rising edge; asynchronous reset clears everything, including the array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the register array is reset too, because cleared contents after reset are part of the interface contract.
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            rd_data_a_q  <= '0;
            rd_data_b_q  <= '0;
            rd_valid_a_q <= 1'b0;
            rd_valid_b_q <= 1'b0;
            rd_err_a_q   <= 1'b0;
            rd_err_b_q   <= 1'b0;
            wr_err_q     <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
            rd_data_a_q  <= rd_data_a_d;
            rd_data_b_q  <= rd_data_b_d;
            rd_valid_a_q <= rd_valid_a_d;
            rd_valid_b_q <= rd_valid_b_d;
            rd_err_a_q   <= rd_err_a_d;
            rd_err_b_q   <= rd_err_b_d;
            wr_err_q     <= wr_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign rd_data_a  = rd_data_a_q;
    assign rd_data_b  = rd_data_b_q;
    assign rd_valid_a = rd_valid_a_q;
    assign rd_valid_b = rd_valid_b_q;
    assign rd_err_a   = rd_err_a_q;
    assign rd_err_b   = rd_err_b_q;
    assign wr_err     = wr_err_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_reg_bank_mp.sv
// tb_reg_bank_mp: directed self-checking bench for reg_bank_mp (default parameters).
module tb_reg_bank_mp;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [1:0]  wr_be;
    logic [15:0] wr_data;
    logic        rd_en_a;
    logic [3:0]  rd_addr_a;
    logic [15:0] rd_data_a;
    logic        rd_valid_a;
    logic        rd_err_a;
    logic        rd_en_b;
    logic [3:0]  rd_addr_b;
    logic [15:0] rd_data_b;
    logic        rd_valid_b;
    logic        rd_err_b;
    logic        wr_err;
    logic        err_clr;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    reg_bank_mp dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_be      (wr_be),
        .wr_data    (wr_data),
        .rd_en_a    (rd_en_a),
        .rd_addr_a  (rd_addr_a),
        .rd_data_a  (rd_data_a),
        .rd_valid_a (rd_valid_a),
        .rd_err_a   (rd_err_a),
        .rd_en_b    (rd_en_b),
        .rd_addr_b  (rd_addr_b),
        .rd_data_b  (rd_data_b),
        .rd_valid_b (rd_valid_b),
        .rd_err_b   (rd_err_b),
        .wr_err     (wr_err),
        .err_clr    (err_clr),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        wr_en = 0; wr_addr = 0; wr_be = 0; wr_data = 0;
        rd_en_a = 0; rd_addr_a = 0; rd_en_b = 0; rd_addr_b = 0;
        err_clr = 0;
    endtask

    // Apply the current inputs across one rising edge, leave them idle, settle 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_write(input logic [3:0] a, input logic [1:0] be, input logic [15:0] d);
        wr_en = 1; wr_addr = a; wr_be = be; wr_data = d;
        step();
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        #23;
        rst = 0;
        #1;
        n_checks++;
        if (err_cnt !== 8'd0 || wr_err !== 1'b0 || rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_outputs: err_cnt=%0d wr_err=%b vA=%b vB=%b, expected 0 0 0 0",
                     err_cnt, wr_err, rd_valid_a, rd_valid_b);
        end
        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            rd_en_a = 1; rd_addr_a = 4'(i);
            rd_en_b = 1; rd_addr_b = 4'(13 - i);
            step();
            n_checks++;
            if (rd_data_a !== 16'h0000 || rd_valid_a !== 1'b1 || rd_err_a !== 1'b0 ||
                rd_data_b !== 16'h0000 || rd_valid_b !== 1'b1 || rd_err_b !== 1'b0) begin
                n_fails++;
                $display("FAIL reset_read[%0d]: A=%h/%b/%b B=%h/%b/%b, expected 0000/1/0 both",
                         i, rd_data_a, rd_valid_a, rd_err_a, rd_data_b, rd_valid_b, rd_err_b);
            end
        end
    endtask

    task automatic test_byte_enable();
        do_write(4'd3, 2'b11, 16'h1234);
        do_write(4'd3, 2'b01, 16'hABCD);
        rd_en_a = 1; rd_addr_a = 4'd3;
        step();
        n_checks++;
        if (rd_data_a !== 16'h12CD) begin
            n_fails++;
            $display("FAIL byte_enable_low: got %h, expected 12cd", rd_data_a);
        end
        // Idle port: data holds, valid drops.
        step();
        n_checks++;
        if (rd_data_a !== 16'h12CD || rd_valid_a !== 1'b0 || rd_err_a !== 1'b0) begin
            n_fails++;
            $display("FAIL idle_hold: got %h/%b/%b, expected 12cd/0/0", rd_data_a, rd_valid_a, rd_err_a);
        end
        // wr_be = 0: no change, no error.
        do_write(4'd3, 2'b00, 16'hFFFF);
        n_checks++;
        if (wr_err !== 1'b0) begin
            n_fails++;
            $display("FAIL be_zero_err: wr_err=%b, expected 0", wr_err);
        end
        do_write(4'd3, 2'b10, 16'h77EE);
        rd_en_b = 1; rd_addr_b = 4'd3;
        step();
        n_checks++;
        if (rd_data_b !== 16'h77CD) begin
            n_fails++;
            $display("FAIL byte_enable_high: got %h, expected 77cd", rd_data_b);
        end
    endtask

    task automatic test_dual_read();
        do_write(4'd5, 2'b11, 16'hAAAA);
        do_write(4'd9, 2'b11, 16'h5555);
        rd_en_a = 1; rd_addr_a = 4'd5;
        rd_en_b = 1; rd_addr_b = 4'd9;
        step();
        n_checks++;
        if (rd_data_a !== 16'hAAAA || rd_data_b !== 16'h5555 || rd_valid_a !== 1'b1 || rd_valid_b !== 1'b1) begin
            n_fails++;
            $display("FAIL dual_read: A=%h B=%h vA=%b vB=%b, expected aaaa 5555 1 1",
                     rd_data_a, rd_data_b, rd_valid_a, rd_valid_b);
        end
        rd_en_a = 1; rd_addr_a = 4'd9;
        rd_en_b = 1; rd_addr_b = 4'd9;
        step();
        n_checks++;
        if (rd_data_a !== 16'h5555 || rd_data_b !== 16'h5555) begin
            n_fails++;
            $display("FAIL same_addr_read: A=%h B=%h, expected 5555 5555", rd_data_a, rd_data_b);
        end
    endtask

    task automatic test_errors();
        // Load A with a nonzero value so the zeroed error read is visible.
        rd_en_a = 1; rd_addr_a = 4'd5;
        step();
        wr_en = 1; wr_addr = 4'd14; wr_be = 2'b11; wr_data = 16'hDEAD;
        rd_en_a = 1; rd_addr_a = 4'd15;
        step();
        n_checks++;
        if (wr_err !== 1'b1 || rd_err_a !== 1'b1 || rd_valid_a !== 1'b1 || rd_data_a !== 16'h0000 ||
            err_cnt !== 8'd2 || rd_err_b !== 1'b0) begin
            n_fails++;
            $display("FAIL invalid_access: wr_err=%b errA=%b vA=%b A=%h cnt=%0d errB=%b, expected 1 1 1 0000 2 0",
                     wr_err, rd_err_a, rd_valid_a, rd_data_a, err_cnt, rd_err_b);
        end
        step();
        n_checks++;
        if (wr_err !== 1'b0 || rd_err_a !== 1'b0 || err_cnt !== 8'd2) begin
            n_fails++;
            $display("FAIL err_one_cycle: wr_err=%b errA=%b cnt=%0d, expected 0 0 2", wr_err, rd_err_a, err_cnt);
        end
        // Legal registers untouched by the invalid write.
        rd_en_a = 1; rd_addr_a = 4'd3;
        rd_en_b = 1; rd_addr_b = 4'd13;
        step();
        n_checks++;
        if (rd_data_a !== 16'h77CD || rd_data_b !== 16'h0000) begin
            n_fails++;
            $display("FAIL no_reg_change: A=%h B=%h, expected 77cd 0000", rd_data_a, rd_data_b);
        end
        for (int i = 0; i < 300; i++) begin
            wr_en = 1; wr_addr = 4'd14; wr_be = 2'b11; wr_data = 16'hDEAD;
            rd_en_a = 1; rd_addr_a = 4'd15;
            step();
        end
        n_checks++;
        if (err_cnt !== 8'd255) begin
            n_fails++;
            $display("FAIL err_saturate: got %0d, expected 255", err_cnt);
        end
        err_clr = 1; wr_en = 1; wr_addr = 4'd15; wr_be = 2'b01;
        step();
        n_checks++;
        if (err_cnt !== 8'd1) begin
            n_fails++;
            $display("FAIL clr_with_error: got %0d, expected 1", err_cnt);
        end
        err_clr = 1; wr_en = 1; wr_addr = 4'd14;
        rd_en_a = 1; rd_addr_a = 4'd14; rd_en_b = 1; rd_addr_b = 4'd15;
        step();
        n_checks++;
        if (err_cnt !== 8'd3 || rd_err_b !== 1'b1 || rd_data_b !== 16'h0000) begin
            n_fails++;
            $display("FAIL clr_with_three: cnt=%0d errB=%b B=%h, expected 3 1 0000", err_cnt, rd_err_b, rd_data_b);
        end
        err_clr = 1;
        step();
        n_checks++;
        if (err_cnt !== 8'd0) begin
            n_fails++;
            $display("FAIL clr_alone: got %0d, expected 0", err_cnt);
        end
    endtask

    task automatic test_rw_collision();
        logic [15:0] exp_full, exp_part;
`ifdef REG_BANK_BYPASS_EN
        exp_full = 16'hFFFF;
        exp_part = 16'hFF34;
`else
        exp_full = 16'h8000;
        exp_part = 16'hFFFF;
`endif
        do_write(4'd0, 2'b11, 16'h8000);
        wr_en = 1; wr_addr = 4'd0; wr_be = 2'b11; wr_data = 16'hFFFF;
        rd_en_a = 1; rd_addr_a = 4'd0;
        step();
        n_checks++;
        if (rd_data_a !== exp_full) begin
            n_fails++;
            $display("FAIL collision_full: got %h, expected %h", rd_data_a, exp_full);
        end
        wr_en = 1; wr_addr = 4'd0; wr_be = 2'b01; wr_data = 16'h1234;
        rd_en_b = 1; rd_addr_b = 4'd0;
        rd_en_a = 1; rd_addr_a = 4'd5;
        step();
        n_checks++;
        if (rd_data_b !== exp_part || rd_data_a !== 16'hAAAA) begin
            n_fails++;
            $display("FAIL collision_partial: B=%h A=%h, expected %h aaaa", rd_data_b, rd_data_a, exp_part);
        end
        rd_en_a = 1; rd_addr_a = 4'd0;
        step();
        n_checks++;
        if (rd_data_a !== 16'hFF34) begin
            n_fails++;
            $display("FAIL collision_commit: got %h, expected ff34", rd_data_a);
        end
    endtask

    task automatic test_async_reset();
        rd_en_a = 1; rd_addr_a = 4'd0;
        wr_en = 1; wr_addr = 4'd15; wr_be = 2'b11;
        step();
        n_checks++;
        if (rd_valid_a !== 1'b1 || rd_data_a !== 16'hFF34 || err_cnt !== 8'd1) begin
            n_fails++;
            $display("FAIL pre_reset: vA=%b A=%h cnt=%0d, expected 1 ff34 1", rd_valid_a, rd_data_a, err_cnt);
        end
        // Mid-cycle reset, well away from any rising edge.
        rd_en_a = 1; rd_addr_a = 4'd0;
        #2;
        rst = 1;
        #1;
        n_checks++;
        if (rd_valid_a !== 1'b0 || rd_data_a !== 16'h0000 || err_cnt !== 8'd0 || wr_err !== 1'b0) begin
            n_fails++;
            $display("FAIL async_reset: vA=%b A=%h cnt=%0d wr_err=%b, expected 0 0000 0 0",
                     rd_valid_a, rd_data_a, err_cnt, wr_err);
        end
        #1;
        rst = 0;
        idle();
        @(negedge clk);
        for (int i = 0; i < 14; i += 2) begin
            rd_en_a = 1; rd_addr_a = 4'(i);
            rd_en_b = 1; rd_addr_b = 4'(i + 1);
            step();
            n_checks++;
            if (rd_data_a !== 16'h0000 || rd_data_b !== 16'h0000 || rd_err_a !== 1'b0 || rd_err_b !== 1'b0) begin
                n_fails++;
                $display("FAIL post_reset_read[%0d]: A=%h B=%h errA=%b errB=%b, expected 0000 0000 0 0",
                         i, rd_data_a, rd_data_b, rd_err_a, rd_err_b);
            end
        end
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_byte_enable();
        test_dual_read();
        test_errors();
        test_rw_collision();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
